// File: rtl/motor_pkg.sv
// Shared types and the ramp step helper for the motor ramp controller.
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DEAD  = 3'd2,
        ST_FAULT = 3'd3
    } motor_state_t;

    typedef logic [7:0] duty_t;

    // Move cur toward eff by at most step. The math is done in 9 bits so
    // that neither direction can wrap past 0 or 255.
    function automatic duty_t ramp_step(duty_t cur, duty_t eff, logic [8:0] step);
        logic [8:0] up;
        logic [8:0] dn;
        duty_t      nxt;
        up  = {1'b0, cur} + step;
        dn  = {1'b0, cur} - step;
        nxt = cur;
        if (eff > cur)
            nxt = (up > {1'b0, eff}) ? eff : up[7:0];
        else if (eff < cur)
            nxt = (dn[8] || (dn[7:0] < eff)) ? eff : dn[7:0];
        return nxt;
    endfunction

endpackage

// File: rtl/motor_ramp_ctrl_tick_gen.sv
// Free-running prescaler: a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
    parameter int CLK_HZ  = 25000000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Ramped duty/direction controller with dead time on reversal and latched estop.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int TICK_HZ    = 1000,
    parameter int STEP       = 8,
    parameter int DEAD_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       estop,
    input  logic [7:0] target_duty,
    input  logic       target_dir,
    output duty_t      duty_cycle,
    output logic       direction,
    output logic       drv_enable,
    output logic       at_target,
    output logic       fault,
    output logic [2:0] state
);
    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    motor_state_t  st;
    logic [DW-1:0] dead_cnt;
    logic          tick;
    duty_t         eff;
    logic          want_run;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A direction mismatch or a dropped enable ramps down to zero first.
    assign eff      = (enable && (target_dir == direction)) ? target_duty : 8'd0;
    assign want_run = enable && (target_duty != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_IDLE;
            duty_cycle <= '0;
            direction  <= 1'b0;
            drv_enable <= 1'b0;
            fault      <= 1'b0;
            dead_cnt   <= '0;
        end else if (estop) begin
            st         <= ST_FAULT;
            duty_cycle <= '0;
            drv_enable <= 1'b0;
            fault      <= 1'b1;
        end else begin
            case (st)
                ST_IDLE: begin
                    duty_cycle <= '0;
                    if (want_run) begin
                        st         <= ST_RUN;
                        direction  <= target_dir;
                        drv_enable <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (duty_cycle == 8'd0 && eff == 8'd0) begin
                        st         <= ST_DEAD;
                        dead_cnt   <= '0;
                        drv_enable <= 1'b0;
                    end else if (tick) begin
                        duty_cycle <= ramp_step(duty_cycle, eff, STEP9);
                    end
                end
                ST_DEAD: begin
                    if (tick) begin
                        if (dead_cnt == DEAD_LAST) begin
                            if (want_run) begin
                                st         <= ST_RUN;
                                direction  <= target_dir;
                                drv_enable <= 1'b1;
                            end else begin
                                st <= ST_IDLE;
                            end
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    duty_cycle <= '0;
                    if (!enable) begin
                        st    <= ST_IDLE;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    st         <= ST_IDLE;
                    duty_cycle <= '0;
                    drv_enable <= 1'b0;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

    assign at_target = (st == ST_RUN) && enable && (duty_cycle == target_duty)
                       && (direction == target_dir);
    assign state     = st;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with a 10-clock tick period.
module tb_motor_ramp_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       estop = 1'b0;
    logic [7:0] target_duty = 8'd0;
    logic       target_dir = 1'b0;
    logic [7:0] duty_cycle;
    logic       direction;
    logic       drv_enable;
    logic       at_target;
    logic       fault;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_DEAD = 3'd2, S_FAULT = 3'd3;

    motor_ramp_ctrl #(
        .CLK_HZ     (100),
        .TICK_HZ    (10),
        .STEP       (8),
        .DEAD_TICKS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .estop       (estop),
        .target_duty (target_duty),
        .target_dir  (target_dir),
        .duty_cycle  (duty_cycle),
        .direction   (direction),
        .drv_enable  (drv_enable),
        .at_target   (at_target),
        .fault       (fault),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Bench-side clock count since reset release; the tick fires on edges where it reaches 9 mod 10.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic next_tick;
        do @(negedge clk); while (cyc % 10 != 9);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({duty_cycle, direction, drv_enable, at_target, fault, state} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got duty=%0d dir=%b drv=%b at=%b fault=%b st=%0d exp all zero",
                     duty_cycle, direction, drv_enable, at_target, fault, state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ramp_up;
        logic [7:0] exp_d [3];
        exp_d = '{8'd8, 8'd16, 8'd20};
        enable = 1'b1; target_duty = 8'd20; target_dir = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (state !== S_RUN || drv_enable !== 1'b1 || duty_cycle !== 8'd0 || direction !== 1'b0) begin
            failures++;
            $display("FAIL ramp_enter got st=%0d drv=%b duty=%0d dir=%b exp st=1 drv=1 duty=0 dir=0",
                     state, drv_enable, duty_cycle, direction);
        end
        for (int i = 0; i < 3; i++) begin
            next_tick();
            checks++;
            if (duty_cycle !== exp_d[i]) begin
                failures++;
                $display("FAIL ramp_up[%0d] got duty=%0d exp %0d", i, duty_cycle, exp_d[i]);
            end
        end
        checks++;
        if (at_target !== 1'b1) begin
            failures++;
            $display("FAIL ramp_at_target got %b exp 1", at_target);
        end
    endtask

    task automatic test_reversal;
        logic [7:0] dn_d [3];
        logic [7:0] up_d [3];
        dn_d = '{8'd12, 8'd4, 8'd0};
        up_d = '{8'd8, 8'd16, 8'd20};
        target_dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_tick();
            checks++;
            if (duty_cycle !== dn_d[i] || state !== S_RUN) begin
                failures++;
                $display("FAIL rev_down[%0d] got duty=%0d st=%0d exp duty=%0d st=1", i, duty_cycle, state, dn_d[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (state !== S_DEAD || drv_enable !== 1'b0) begin
            failures++;
            $display("FAIL rev_dead_entry got st=%0d drv=%b exp st=2 drv=0", state, drv_enable);
        end
        for (int i = 0; i < 2; i++) begin
            next_tick();
            checks++;
            if (state !== S_DEAD || drv_enable !== 1'b0 || direction !== 1'b0) begin
                failures++;
                $display("FAIL rev_dead[%0d] got st=%0d drv=%b dir=%b exp st=2 drv=0 dir=0",
                         i, state, drv_enable, direction);
            end
        end
        next_tick();
        checks++;
        if (state !== S_RUN || drv_enable !== 1'b1 || direction !== 1'b1 || duty_cycle !== 8'd0) begin
            failures++;
            $display("FAIL rev_dead_exit got st=%0d drv=%b dir=%b duty=%0d exp st=1 drv=1 dir=1 duty=0",
                     state, drv_enable, direction, duty_cycle);
        end
        for (int i = 0; i < 3; i++) begin
            next_tick();
            checks++;
            if (duty_cycle !== up_d[i]) begin
                failures++;
                $display("FAIL rev_up[%0d] got duty=%0d exp %0d", i, duty_cycle, up_d[i]);
            end
        end
        checks++;
        if (at_target !== 1'b1) begin
            failures++;
            $display("FAIL rev_at_target got %b exp 1", at_target);
        end
    endtask

    task automatic test_saturation;
        int exp;
        exp = 20;
        target_duty = 8'd240;
        while (exp != 240) begin
            next_tick();
            exp = (exp + 8 > 240) ? 240 : exp + 8;
            checks++;
            if (duty_cycle !== 8'(exp)) begin
                failures++;
                $display("FAIL sat_climb got duty=%0d exp %0d", duty_cycle, exp);
            end
        end
        target_duty = 8'd255;
        next_tick();
        checks++;
        if (duty_cycle !== 8'd248) begin
            failures++;
            $display("FAIL sat_248 got duty=%0d exp 248", duty_cycle);
        end
        for (int i = 0; i < 2; i++) begin
            next_tick();
            checks++;
            if (duty_cycle !== 8'd255 || at_target !== 1'b1) begin
                failures++;
                $display("FAIL sat_255[%0d] got duty=%0d at=%b exp duty=255 at=1", i, duty_cycle, at_target);
            end
        end
        target_duty = 8'd3;
        exp = 255;
        while (exp != 3) begin
            next_tick();
            exp = (exp - 8 < 3) ? 3 : exp - 8;
            checks++;
            if (duty_cycle !== 8'(exp)) begin
                failures++;
                $display("FAIL sat_descend got duty=%0d exp %0d", duty_cycle, exp);
            end
        end
        next_tick();
        checks++;
        if (duty_cycle !== 8'd3 || at_target !== 1'b1) begin
            failures++;
            $display("FAIL sat_floor got duty=%0d at=%b exp duty=3 at=1", duty_cycle, at_target);
        end
    endtask

    task automatic test_estop;
        target_duty = 8'd16;
        next_tick();
        next_tick();
        checks++;
        if (duty_cycle !== 8'd16) begin
            failures++;
            $display("FAIL estop_pre got duty=%0d exp 16", duty_cycle);
        end
        @(negedge clk);
        estop = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (duty_cycle !== 8'd0 || fault !== 1'b1 || state !== S_FAULT || drv_enable !== 1'b0 || at_target !== 1'b0) begin
            failures++;
            $display("FAIL estop_hit got duty=%0d fault=%b st=%0d drv=%b at=%b exp 0 1 3 0 0",
                     duty_cycle, fault, state, drv_enable, at_target);
        end
        @(negedge clk);
        estop = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (state !== S_FAULT || fault !== 1'b1 || direction !== 1'b1) begin
            failures++;
            $display("FAIL estop_hold got st=%0d fault=%b dir=%b exp st=3 fault=1 dir=1", state, fault, direction);
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (state !== S_IDLE || fault !== 1'b0 || duty_cycle !== 8'd0 || direction !== 1'b1) begin
            failures++;
            $display("FAIL estop_release got st=%0d fault=%b duty=%0d dir=%b exp st=0 fault=0 duty=0 dir=1",
                     state, fault, duty_cycle, direction);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        enable = 1'b1; target_duty = 8'd20; target_dir = 1'b1;
        @(posedge clk); #1;
        next_tick();
        checks++;
        if (state !== S_RUN || duty_cycle !== 8'd8 || direction !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre got st=%0d duty=%0d dir=%b exp st=1 duty=8 dir=1", state, duty_cycle, direction);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        checks++;
        if ({duty_cycle, direction, drv_enable, at_target, fault, state} !== 14'd0) begin
            failures++;
            $display("FAIL areset_mid got duty=%0d dir=%b drv=%b at=%b fault=%b st=%0d exp all zero",
                     duty_cycle, direction, drv_enable, at_target, fault, state);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (state !== S_IDLE || duty_cycle !== 8'd0) begin
            failures++;
            $display("FAIL areset_after got st=%0d duty=%0d exp st=0 duty=0", state, duty_cycle);
        end
    endtask

    task automatic test_disable;
        logic [7:0] up_d [3];
        logic [7:0] dn_d [3];
        up_d = '{8'd8, 8'd16, 8'd20};
        dn_d = '{8'd12, 8'd4, 8'd0};
        @(negedge clk);
        enable = 1'b1; target_duty = 8'd20; target_dir = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            next_tick();
            checks++;
            if (duty_cycle !== up_d[i]) begin
                failures++;
                $display("FAIL dis_up[%0d] got duty=%0d exp %0d", i, duty_cycle, up_d[i]);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_tick();
            checks++;
            if (duty_cycle !== dn_d[i] || at_target !== 1'b0) begin
                failures++;
                $display("FAIL dis_down[%0d] got duty=%0d at=%b exp duty=%0d at=0", i, duty_cycle, at_target, dn_d[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (state !== S_DEAD || drv_enable !== 1'b0) begin
            failures++;
            $display("FAIL dis_dead_entry got st=%0d drv=%b exp st=2 drv=0", state, drv_enable);
        end
        for (int i = 0; i < 2; i++) begin
            next_tick();
            checks++;
            if (state !== S_DEAD) begin
                failures++;
                $display("FAIL dis_dead[%0d] got st=%0d exp 2", i, state);
            end
        end
        next_tick();
        checks++;
        if (state !== S_IDLE || drv_enable !== 1'b0 || duty_cycle !== 8'd0) begin
            failures++;
            $display("FAIL dis_idle got st=%0d drv=%b duty=%0d exp st=0 drv=0 duty=0", state, drv_enable, duty_cycle);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_reversal();
        test_saturation();
        test_estop();
        test_async_reset();
        test_disable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
